axis_slip_decoder: RTL and testbench
====================================

Name: axis_slip_decoder

Overview:
- Sits directly downstream of the UART receiver's AXI-Stream master port.
- Turns the raw received byte stream into SLIP-delimited frames (RFC 1055): strips END, un-escapes ESC sequences, and emits an 8-bit AXI-Stream with tlast on the final byte.
- tuser on the last beat flags a bad frame.
- Feeds the packet/MAC-side logic of the design.

Parameters:
- MAX_LEN, 1518, maximum decoded bytes per frame; excess bytes are truncated and the frame is flagged bad.
- LEN_WIDTH, 11, width of the frame byte counter; must satisfy 2^LEN_WIDTH > MAX_LEN.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_axis_tdata  in  16  UART byte; only [7:0] used, [15:8] ignored
- s_axis_tuser  in  1  parity error on this byte
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  8  decoded byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last byte of frame
- m_axis_tuser  out  1  frame error; meaningful only with tlast
- frame_done  out  1  one-cycle pulse when a last beat is loaded into the output register
- frame_error  out  1  one-cycle pulse coincident with frame_done when tuser=1

Behaviour:
- Reset: already decided — one clock (aclk); reset (areset) is asynchronous and active-high. Under reset all outputs are 0, state=HUNT, hold_valid=0, err=0, len=0.
- Constants: END=0xC0, ESC=0xDB, ESC_END=0xDC, ESC_ESC=0xDD.
- Output register plus a one-byte hold register. hold stores the most recent decoded byte, so tlast can be attached when END arrives.
- out_free = !m_axis_tvalid | m_axis_tready.
- s_axis_tready = out_free (combinational). An input byte is consumed only on s_axis_tvalid & s_axis_tready.
- Each consumed byte loads at most one output beat.
- m_axis_tvalid/tdata/tlast/tuser hold stable while tvalid=1 and tready=0.
- Latency: a data byte reaches the output on the cycle after the next consumed data byte or END.
- States:
  - HUNT: discard everything until END, then go to DATA. Guarantees sync after reset or an unframed start.
  - DATA, on END:
    - If hold_valid: emit hold with tlast=1, tuser=err; pulse frame_done, and frame_error if err.
    - Else (empty frame): emit nothing.
    - Either way: clear hold_valid, err and len; stay in DATA.
  - DATA, on ESC: go to ESC.
  - DATA, on any other byte: treat as a decoded byte d.
  - ESC, on 0xDC: d=0xC0, return to DATA.
  - ESC, on 0xDD: d=0xDB, return to DATA.
  - ESC, on END: set err, then handle END exactly as in DATA.
  - ESC, on any other byte: drop it, set err, return to DATA.
  - DROP: discard bytes until END, then handle END as in DATA with err forced to 1.
- Decoded byte d:
  - If len == MAX_LEN: set err, go to DROP, and leave hold untouched (it becomes the truncated last byte).
  - Else: if hold_valid, emit hold with tlast=0, tuser=0; then hold<=d, hold_valid=1, len<=len+1.
- s_axis_tuser=1 on any consumed byte, including END/ESC, sets err for the current frame.
- On an END, err applies to the frame being closed and is cleared afterwards.
- Back-to-back END bytes produce no output.
- Back-pressure: while m_axis_tready=0 with valid output, no input is consumed and no state changes.
- Reset mid-frame: the partial frame is lost, the output beat is dropped, and the block returns to HUNT.

Decomposition:
- Shared package slip_pkg: SLIP_END, SLIP_ESC, SLIP_ESC_END, SLIP_ESC_ESC byte constants and the state enumeration (HUNT, DATA, ESC, DROP).
- Single module; no sub-module needed. The output register is inline (about 200 lines of RTL).

Test Plan:
- After reset, send 0x11 0x22 C0 → nothing emitted (HUNT). Then send 0x41 0x42 0x43 C0 → beats 0x41, 0x42, 0x43 with tlast only on 0x43, tuser=0, one frame_done pulse.
- C0 then 0xDB 0xDC 0x01 0xDB 0xDD C0 → beats 0xC0, 0x01, 0xDB; tlast on 0xDB; tuser=0.
- C0 then 0x05, 0xDB 0x07, 0x09, C0 → beats 0x05, 0x09(last) with tuser=1; frame_error pulses.
- MAX_LEN=4: C0, 6 data bytes 0x01..0x06, C0 → beats 0x01..0x04, tlast on 0x04, tuser=1. Bytes 0x05 and 0x06 are dropped.
- C0 C0 C0, then 0xAA with s_axis_tuser=1, then C0 → a single beat 0xAA, tlast=1, tuser=1; the empty frames emit nothing.
- Random m_axis_tready toggling over a 64-byte frame → output sequence identical to the tready=1 case, no lost or duplicated beats, outputs stable while stalled. Assert areset mid-frame → all outputs 0 immediately, and the next frame decodes correctly after a C0.

Source files
------------

// File: rtl/axis_slip_decoder_pkg.sv
// Purpose: SLIP byte codes and decoder state encoding shared by the decoder and its users.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    // HUNT: waiting for the first END after reset
    // DATA: inside a frame, normal bytes
    // ESC : previous byte was ESC
    // DROP: frame overflowed, discarding until END
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        ESC  = 2'd2,
        DROP = 2'd3
    } state_t;

endpackage

// File: rtl/axis_slip_decoder_if.sv
// Purpose: AXI-Stream bundle (tdata/tvalid/tready/tlast/tuser) with master and slave views.
// Latency: n/a (wires only).
// Backpressure: tready driven by the slave side; master holds its beat while tready=0.
interface axis_slip_decoder_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/axis_slip_decoder.sv
// Purpose: SLIP (RFC 1055) frame decoder: strips END, un-escapes ESC pairs, marks tlast/tuser.
// Latency: a decoded byte appears the cycle after the next consumed data byte or END.
// Backpressure: s_axis.tready = output register free; a stalled output freezes all state.
//
// Ports:
//   aclk, areset  clock, asynchronous active-high reset
//   s_axis        16-bit UART byte stream (only [7:0] used, tuser = parity error)
//   m_axis        8-bit decoded stream, tlast on final byte, tuser on tlast = bad frame
//   frame_done    one-cycle pulse when a last beat is loaded into the output register
//   frame_error   pulse coincident with frame_done when that last beat carries tuser=1
module axis_slip_decoder
    import slip_pkg::*;
#(
    parameter int MAX_LEN   = 1518,
    parameter int LEN_WIDTH = 11
) (
    input  logic                aclk,
    input  logic                areset,
    axis_slip_decoder_if.slave  s_axis,
    axis_slip_decoder_if.master m_axis,
    output logic                frame_done,
    output logic                frame_error
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

    state_t               state, state_n;
    logic [7:0]           hold_dat, hold_dat_n;
    logic                 hold_vld, hold_vld_n;
    logic                 err, err_n;
    logic [LEN_WIDTH-1:0] len, len_n;

    logic [7:0] out_dat;
    logic       out_vld, out_last, out_user;
    logic       done_q, derr_q;

    logic       out_free;
    logic       take;
    logic [7:0] in_byte;

    logic       emit, emit_last, emit_user;
    logic       have_d, close, err_acc;
    logic [7:0] d;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axis.tdata[15:8], s_axis.tlast};

    assign out_free      = !out_vld || m_axis.tready;
    // Ready is held low during reset so nothing is offered a handshake while flushing.
    assign s_axis.tready = out_free && !areset;
    assign take          = s_axis.tvalid && s_axis.tready;
    assign in_byte       = s_axis.tdata[7:0];

    always_comb begin
        state_n    = state;
        hold_dat_n = hold_dat;
        hold_vld_n = hold_vld;
        err_n      = err;
        len_n      = len;
        emit       = 1'b0;
        emit_last  = 1'b0;
        emit_user  = 1'b0;
        have_d     = 1'b0;
        close      = 1'b0;
        d          = in_byte;
        err_acc    = err | s_axis.tuser;

        if (take) begin
            case (state)
                HUNT: begin
                    // No frame is open yet, so line errors have nothing to attach to.
                    err_acc = 1'b0;
                    if (in_byte == SLIP_END) state_n = DATA;
                end
                DATA: begin
                    if (in_byte == SLIP_END)      close   = 1'b1;
                    else if (in_byte == SLIP_ESC) state_n = ESC;
                    else                          have_d  = 1'b1;
                end
                ESC: begin
                    state_n = DATA;
                    if (in_byte == SLIP_END) begin
                        err_acc = 1'b1;
                        close   = 1'b1;
                    end else if (in_byte == SLIP_ESC_END) begin
                        d      = SLIP_END;
                        have_d = 1'b1;
                    end else if (in_byte == SLIP_ESC_ESC) begin
                        d      = SLIP_ESC;
                        have_d = 1'b1;
                    end else begin
                        err_acc = 1'b1;
                    end
                end
                DROP: begin
                    if (in_byte == SLIP_END) begin
                        err_acc = 1'b1;
                        close   = 1'b1;
                        state_n = DATA;
                    end
                end
                default: state_n = HUNT;
            endcase

            err_n = err_acc;

            if (have_d) begin
                if (len == MAX_LEN_L) begin
                    // Hold keeps the last in-range byte; it closes the frame as the truncated tail.
                    err_n   = 1'b1;
                    state_n = DROP;
                end else begin
                    if (hold_vld) begin
                        emit      = 1'b1;
                        emit_last = 1'b0;
                        emit_user = 1'b0;
                    end
                    hold_dat_n = d;
                    hold_vld_n = 1'b1;
                    len_n      = len + 1'b1;
                end
            end

            if (close) begin
                if (hold_vld) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    emit_user = err_acc;
                end
                hold_vld_n = 1'b0;
                err_n      = 1'b0;
                len_n      = '0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= HUNT;
            hold_dat <= '0;
            hold_vld <= 1'b0;
            err      <= 1'b0;
            len      <= '0;
        end else begin
            state    <= state_n;
            hold_dat <= hold_dat_n;
            hold_vld <= hold_vld_n;
            err      <= err_n;
            len      <= len_n;
        end
    end

    // Output register: a beat is only loaded when the register is free, which is
    // also the only time input is consumed, so emit implies out_free.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_dat  <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_user <= 1'b0;
            done_q   <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            done_q <= emit && emit_last;
            derr_q <= emit && emit_last && emit_user;
            if (out_free) begin
                out_vld <= emit;
                if (emit) begin
                    out_dat  <= hold_dat;
                    out_last <= emit_last;
                    out_user <= emit_user;
                end
            end
        end
    end

    assign m_axis.tdata  = out_dat;
    assign m_axis.tvalid = out_vld;
    assign m_axis.tlast  = out_last;
    assign m_axis.tuser  = out_user;
    assign frame_done    = done_q;
    assign frame_error   = derr_q;

endmodule

// File: tb/tb_axis_slip_decoder.sv
// Purpose: randomized + directed bench for axis_slip_decoder against a frame-level SLIP model.
// Latency: n/a.
// Backpressure: drives random m_axis.tready and input gaps; checks beat stability while stalled.
module tb_axis_slip_decoder;

    localparam int MAXL = 80;
    localparam int LW   = 7;

    logic aclk = 1'b0;
    logic areset;
    logic frame_done, frame_error;

    axis_slip_decoder_if #(.DW(16)) s_if ();
    axis_slip_decoder_if #(.DW(8))  m_if ();

    axis_slip_decoder #(.MAX_LEN(MAXL), .LEN_WIDTH(LW)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [7:0] in_b[$];
    bit         in_u[$];
    logic [9:0] exp_q[$];   // {last, user, data}
    logic [9:0] got_q[$];
    logic [9:0] ref_q[$];
    int in_idx;
    int exp_frames, exp_errs, got_frames, got_errs;
    bit stalled = 1'b0;
    logic [10:0] prev_beat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: split the stream at END bytes, decode each segment,
    // truncate to MAXL, and turn non-empty segments into beats.
    function automatic void build_expected(input bit synced);
        logic [7:0] seg[$];
        logic [7:0] dec[$];
        bit seg_err = 1'b0;
        bit hunting = !synced;
        exp_q.delete();
        exp_frames = 0;
        exp_errs   = 0;
        foreach (in_b[i]) begin
            if (in_b[i] == 8'hC0) begin
                if (!hunting) begin
                    seg_err = seg_err | in_u[i];
                    dec.delete();
                    for (int k = 0; k < seg.size(); k++) begin
                        if (seg[k] == 8'hDB) begin
                            if (k + 1 < seg.size() && seg[k+1] == 8'hDC)      dec.push_back(8'hC0);
                            else if (k + 1 < seg.size() && seg[k+1] == 8'hDD) dec.push_back(8'hDB);
                            else seg_err = 1'b1;
                            k++;
                        end else begin
                            dec.push_back(seg[k]);
                        end
                    end
                    if (dec.size() > MAXL) begin
                        seg_err = 1'b1;
                        while (dec.size() > MAXL) void'(dec.pop_back());
                    end
                    for (int j = 0; j < dec.size(); j++) begin
                        bit last = (j == dec.size() - 1);
                        exp_q.push_back({last, last & seg_err, dec[j]});
                    end
                    if (dec.size() > 0) begin
                        exp_frames++;
                        if (seg_err) exp_errs++;
                    end
                end
                hunting = 1'b0;
                seg.delete();
                seg_err = 1'b0;
            end else if (!hunting) begin
                seg.push_back(in_b[i]);
                seg_err = seg_err | in_u[i];
            end
        end
    endfunction

    // Append one payload byte, escaping it when needed.
    task automatic push_enc(input logic [7:0] v, input bit u);
        if (v == 8'hC0) begin
            in_b.push_back(8'hDB); in_u.push_back(u);
            in_b.push_back(8'hDC); in_u.push_back(1'b0);
        end else if (v == 8'hDB) begin
            in_b.push_back(8'hDB); in_u.push_back(u);
            in_b.push_back(8'hDD); in_u.push_back(1'b0);
        end else begin
            in_b.push_back(v); in_u.push_back(u);
        end
    endtask

    task automatic push_raw(input logic [7:0] v, input bit u);
        in_b.push_back(v);
        in_u.push_back(u);
    endtask

    // mode 0: always ready, 1: random ready and input gaps, 2: never ready
    task automatic cycle(input int mode);
        @(negedge aclk);
        case (mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = ($urandom_range(0, 3) != 0);
            default: m_if.tready = 1'b0;
        endcase
        if (in_idx < in_b.size() && (mode != 1 || $urandom_range(0, 4) != 0)) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = {8'($urandom), in_b[in_idx]};
            s_if.tuser  = in_u[in_idx];
        end else begin
            s_if.tvalid = 1'b0;
            s_if.tdata  = 16'($urandom);
            s_if.tuser  = 1'b0;
        end
        #1;
        if (stalled)
            check("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata}, {1'b1, prev_beat[9:0]});
        stalled   = m_if.tvalid && !m_if.tready;
        prev_beat = {1'b0, m_if.tlast, m_if.tuser, m_if.tdata};
        if (m_if.tvalid && m_if.tready)
            got_q.push_back({m_if.tlast, m_if.tuser, m_if.tdata});
        if (frame_done) begin
            got_frames++;
            check("done_on_last", {m_if.tvalid, m_if.tlast}, 2'b11);
        end
        if (frame_error) begin
            got_errs++;
            check("error_with_done", {frame_done, m_if.tuser}, 2'b11);
        end
        if (s_if.tvalid && s_if.tready) in_idx++;
    endtask

    task automatic run_phase(input string name, input bit synced, input int mode);
        int budget = 0;
        build_expected(synced);
        got_q.delete();
        in_idx     = 0;
        got_frames = 0;
        got_errs   = 0;
        while ((in_idx < in_b.size() || got_q.size() < exp_q.size()) && budget < 20000) begin
            cycle(mode);
            budget++;
        end
        for (int i = 0; i < 4; i++) cycle(mode);
        check({name, "_timeout"}, budget < 20000, 1);
        check({name, "_beats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
        check({name, "_frames"}, got_frames, exp_frames);
        check({name, "_ferrs"}, got_errs, exp_errs);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tdata"},  m_if.tdata, 0);
        check({tag, "_tvalid"}, m_if.tvalid, 0);
        check({tag, "_tlast"},  m_if.tlast, 0);
        check({tag, "_tuser"},  m_if.tuser, 0);
        check({tag, "_done"},   frame_done, 0);
        check({tag, "_ferr"},   frame_error, 0);
        check({tag, "_sready"}, s_if.tready, 0);
    endtask

    initial begin
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check_all_zero("reset");
        @(negedge aclk);
        areset = 1'b0;

        // Unframed garbage is hunted away, then a plain frame.
        in_b = {8'h11, 8'h22, 8'hC0, 8'h41, 8'h42, 8'h43, 8'hC0};
        in_u = {0, 0, 0, 0, 0, 0, 0};
        run_phase("hunt", 1'b0, 0);
        check("hunt_first", got_q.size() > 0 ? got_q[0] : 10'h3FF, {2'b00, 8'h41});

        // Both escape sequences.
        in_b = {8'hC0, 8'hDB, 8'hDC, 8'h01, 8'hDB, 8'hDD, 8'hC0};
        in_u = {0, 0, 0, 0, 0, 0, 0};
        run_phase("esc", 1'b1, 0);

        // Invalid escape drops the byte and flags the frame.
        in_b = {8'hC0, 8'h05, 8'hDB, 8'h07, 8'h09, 8'hC0};
        in_u = {0, 0, 0, 0, 0, 0};
        run_phase("bad_esc", 1'b1, 0);

        // Overlong frame is truncated at MAXL.
        in_b.delete(); in_u.delete();
        push_raw(8'hC0, 0);
        for (int i = 1; i <= MAXL + 5; i++) push_raw(8'(i), 0);
        push_raw(8'hC0, 0);
        run_phase("trunc", 1'b1, 1);
        check("trunc_tail", got_q.size() == MAXL ? got_q[MAXL-1] : 10'h3FF, {2'b11, 8'(MAXL)});

        // Exactly MAXL bytes is a good frame.
        in_b.delete(); in_u.delete();
        push_raw(8'hC0, 0);
        for (int i = 1; i <= MAXL; i++) push_raw(8'(i), 0);
        push_raw(8'hC0, 0);
        run_phase("maxlen", 1'b1, 0);

        // Empty frames emit nothing; parity error flags the frame.
        in_b = {8'hC0, 8'hC0, 8'hC0, 8'hAA, 8'hC0};
        in_u = {0, 0, 0, 1, 0};
        run_phase("empty", 1'b1, 0);

        // 64-byte frame with and without back-pressure must match beat for beat.
        in_b.delete(); in_u.delete();
        push_raw(8'hC0, 0);
        for (int i = 0; i < 64; i++) push_enc(8'($urandom), 0);
        push_raw(8'hC0, 0);
        run_phase("f64_rdy", 1'b1, 0);
        ref_q = got_q;
        run_phase("f64_stall", 1'b1, 1);
        check("f64_same_len", got_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
            check($sformatf("f64_same%0d", i), got_q[i], ref_q[i]);

        // Random multi-frame streams with escapes, errors, overlong and empty frames.
        for (int p = 0; p < 6; p++) begin
            in_b.delete(); in_u.delete();
            push_raw(8'hC0, 0);
            for (int f = 0; f < 5; f++) begin
                int n = $urandom_range(0, 95);
                for (int i = 0; i < n; i++) begin
                    int r = $urandom_range(0, 99);
                    if (r < 3) begin
                        push_raw(8'hDB, 0);
                        push_raw(8'($urandom_range(0, 8'hBF)), 0);
                    end else begin
                        push_enc(8'($urandom), r >= 97);
                    end
                end
                if ($urandom_range(0, 9) == 0) push_raw(8'hDB, 0);
                push_raw(8'hC0, $urandom_range(0, 19) == 0);
            end
            run_phase($sformatf("rand%0d", p), 1'b1, 1);
        end

        // Reset in the middle of a stalled frame.
        in_b = {8'hC0, 8'h01, 8'h02, 8'h03, 8'h04};
        in_u = {0, 0, 0, 0, 0};
        in_idx = 0;
        got_q.delete();
        for (int i = 0; i < 8; i++) cycle(2);
        check("pre_rst_vld", m_if.tvalid, 1);
        #2;
        areset = 1'b1;
        #1;
        check_all_zero("midrst");
        stalled = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        in_b = {8'h33, 8'h44, 8'hC0, 8'h51, 8'h52, 8'hC0};
        in_u = {0, 0, 0, 0, 0, 0};
        run_phase("post_rst", 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
